alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter: WIDTH, 16, operand/result data width.
REQ-002 Parameter: ALU_LATENCY, 1, clock edges from ALU operand sample to valid alu_result (legal range 1-4).
REQ-003 clock  in  1  single clock, all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  instruction fields valid; in_ready  out  1  block can accept.
REQ-006 opcode  in  4  major opcode; funct  in  3  R-type function code.
REQ-007 rs_val  in  WIDTH  first source operand; rt_val  in  WIDTH  second source operand; imm  in  8  immediate, two's complement.
REQ-008 alu_a  out  WIDTH, alu_b  out  WIDTH, alu_ctrl  out  3  operands and operation code driven to the ALU.
REQ-009 alu_result  in  WIDTH, alu_zero  in  1  ALU outputs, valid ALU_LATENCY edges after operand sample.
REQ-010 out_valid  out  1, out_ready  in  1  result handshake; out_result  out  WIDTH; branch_taken  out  1; illegal  out  1.

Function
REQ-011 ALU codes: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT (unsigned less-than, result 1/0).
REQ-012 Decode: opcode 0000 R-type, alu_ctrl=funct, b=rt_val; funct 101-111 illegal.
REQ-013 Decode: 0001 ADDI->ADD, 0010 ANDI->AND, 0011 ORI->OR, 0100 SLTI->SLT, 0111 LW->ADD, 1000 SW->ADD, all with b=sign-extended imm.
REQ-014 Decode: 0101 BEQ and 0110 BNE->SUB with b=rt_val; any other opcode illegal.
REQ-015 alu_a SHALL equal rs_val for every legal instruction.
REQ-016 FSM states IDLE, ISSUE, WAIT, DONE; in_ready=1 only in IDLE.
REQ-017 IDLE: on in_valid&in_ready, register decoded alu_a/alu_b/alu_ctrl, go ISSUE (legal) or DONE with illegal=1, out_result=0 (illegal).
REQ-018 ISSUE: alu_a/alu_b/alu_ctrl stable, one cycle, then WAIT with counter loaded to ALU_LATENCY-1.
REQ-019 WAIT: decrement counter; when counter=0, capture alu_result and alu_zero at that edge and go DONE.
REQ-020 Accept-to-out_valid latency SHALL be ALU_LATENCY+2 edges for legal, 1 edge for illegal instructions.
REQ-021 branch_taken: BEQ =alu_zero, BNE =~alu_zero, 0 for all other opcodes; out_result for branches = ALU difference.
REQ-022 DONE: out_valid=1; out_result, branch_taken, illegal held stable until out_valid&out_ready, then IDLE next edge.
REQ-023 alu_a/alu_b/alu_ctrl SHALL hold their last issued values outside ISSUE (no glitching to ALU).
REQ-024 in_valid while not IDLE SHALL be ignored; no instruction is buffered beyond one.
REQ-025 Sign-extension SHALL replicate imm[7] into bits WIDTH-1:8.

Reset
REQ-026 reset asserted at any time, including mid-ISSUE/WAIT/DONE, SHALL force IDLE immediately and discard the in-flight instruction.
REQ-027 Reset values: in_ready=1 after reset released, out_valid=0, out_result=0, branch_taken=0, illegal=0, alu_a=0, alu_b=0, alu_ctrl=000, counter=0.

Structure
REQ-028 ALU codes, opcode constants and FSM state encoding SHALL reside in the shared processor package used by the EX stage.
REQ-029 Decode (REQ-012..014, REQ-025) SHALL be one combinational sub-module alu_op_decode; FSM, counter and output registers in alu_issue_ctrl.

Verification
REQ-030 ADD R-type rs=0x0005, rt=0x0003, funct=010 -> alu_ctrl=010, out_result=0x0008, out_valid ALU_LATENCY+2 edges after accept.
REQ-031 ADDI rs=0x0010, imm=0xFF -> alu_b=0xFFFF, out_result=0x000F; SLTI rs=0x0001, imm=0x02 -> out_result=0x0001.
REQ-032 BEQ rs=rt=0x1234 -> branch_taken=1, out_result=0x0000; BNE same operands -> branch_taken=0.
REQ-033 opcode=1111 -> illegal=1, out_result=0, out_valid next edge, alu_* unchanged; funct=110 R-type -> illegal=1.
REQ-034 out_ready held 0 for 5 cycles in DONE -> out_* stable, in_ready=0, second in_valid ignored; release -> IDLE, in_ready=1.
REQ-035 reset pulsed during WAIT -> out_valid=0, all outputs at reset values asynchronously; next instruction completes correctly.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared EX-stage definitions: ALU operation codes, major opcodes and the
// issue-controller state encoding.
package alu_issue_ctrl_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b011,
    ALU_SLT = 3'b100
  } alu_op_e;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_ANDI  = 4'b0010;
  localparam logic [3:0] OP_ORI   = 4'b0011;
  localparam logic [3:0] OP_SLTI  = 4'b0100;
  localparam logic [3:0] OP_BEQ   = 4'b0101;
  localparam logic [3:0] OP_BNE   = 4'b0110;
  localparam logic [3:0] OP_LW    = 4'b0111;
  localparam logic [3:0] OP_SW    = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } issue_state_e;

endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// alu_op_decode: combinational instruction decode for the ALU issue stage.
// Ports:
//   opcode, funct         - major opcode / R-type function code
//   rs_val, rt_val, imm   - source operands and 8-bit signed immediate
//   alu_a, alu_b, alu_ctrl- operands and ALU code for a legal instruction
//   illegal               - opcode or funct not supported
//   is_beq, is_bne        - branch kind, used to form branch_taken later
module alu_op_decode
  import alu_issue_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       opcode,
  input  logic [2:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [7:0]       imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  output logic             illegal,
  output logic             is_beq,
  output logic             is_bne
);

  logic [WIDTH-1:0] imm_sext;

  assign imm_sext = {{(WIDTH-8){imm[7]}}, imm};
  assign alu_a    = rs_val;

  always_comb begin
    alu_b    = imm_sext;
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        alu_b    = rt_val;
        alu_ctrl = funct;
        illegal  = (funct > ALU_SLT);
      end
      OP_ADDI, OP_LW, OP_SW: alu_ctrl = ALU_ADD;
      OP_ANDI:               alu_ctrl = ALU_AND;
      OP_ORI:                alu_ctrl = ALU_OR;
      OP_SLTI:               alu_ctrl = ALU_SLT;
      OP_BEQ: begin
        alu_b    = rt_val;
        alu_ctrl = ALU_SUB;
        is_beq   = 1'b1;
      end
      OP_BNE: begin
        alu_b    = rt_val;
        alu_ctrl = ALU_SUB;
        is_bne   = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts one instruction, drives operands to an external
// ALU with ALU_LATENCY edges of latency, captures its result and presents
// it on a valid/ready output handshake.
// Ports:
//   clock, reset                   - clock, async active-high reset
//   in_valid/in_ready              - instruction accept handshake
//   opcode, funct, rs_val, rt_val, imm - instruction fields
//   alu_a, alu_b, alu_ctrl         - registered operands/code to the ALU
//   alu_result, alu_zero           - ALU outputs
//   out_valid/out_ready            - result handshake
//   out_result, branch_taken, illegal - result fields, held while out_valid
//
// state | meaning
// IDLE  | ready for an instruction
// ISSUE | operands presented to the ALU for its sample edge
// WAIT  | counting down ALU latency, result captured when counter hits 0
// DONE  | result presented until out_ready
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int ALU_LATENCY = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [2:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [7:0]       imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             branch_taken,
  output logic             illegal
);

  localparam int              CNT_W    = 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LATENCY - 1);

  issue_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             beq_q, bne_q;

  logic [WIDTH-1:0] dec_a, dec_b;
  logic [2:0]       dec_ctrl;
  logic             dec_illegal, dec_beq, dec_bne;

  alu_op_decode #(.WIDTH(WIDTH)) u_decode (
    .opcode   (opcode),
    .funct    (funct),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .imm      (imm),
    .alu_a    (dec_a),
    .alu_b    (dec_b),
    .alu_ctrl (dec_ctrl),
    .illegal  (dec_illegal),
    .is_beq   (dec_beq),
    .is_bne   (dec_bne)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = dec_illegal ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ALU operand registers only change on a legal accept, so an illegal
  // instruction never disturbs what the ALU sees.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_ctrl     <= ALU_AND;
      cnt_q        <= '0;
      beq_q        <= 1'b0;
      bne_q        <= 1'b0;
      out_result   <= '0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            illegal      <= dec_illegal;
            out_result   <= '0;
            branch_taken <= 1'b0;
            if (!dec_illegal) begin
              alu_a    <= dec_a;
              alu_b    <= dec_b;
              alu_ctrl <= dec_ctrl;
              beq_q    <= dec_beq;
              bne_q    <= dec_bne;
            end
          end
        end
        ST_ISSUE: cnt_q <= CNT_LOAD;
        ST_WAIT: begin
          if (cnt_q == '0) begin
            out_result   <= alu_result;
            branch_taken <= (beq_q & alu_zero) | (bne_q & ~alu_zero);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  localparam int LAT = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [3:0]  opcode;
  logic [2:0]  funct;
  logic [15:0] rs_val, rt_val;
  logic [7:0]  imm;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_ctrl;
  logic [15:0] alu_result;
  logic        alu_zero;
  logic        out_valid, out_ready;
  logic [15:0] out_result;
  logic        branch_taken, illegal;

  int n_chk  = 0;
  int n_fail = 0;

  alu_issue_ctrl #(.WIDTH(16), .ALU_LATENCY(LAT)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .funct        (funct),
    .rs_val       (rs_val),
    .rt_val       (rt_val),
    .imm          (imm),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_ctrl     (alu_ctrl),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .branch_taken (branch_taken),
    .illegal      (illegal)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] c);
    case (c)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd3:    return a - b;
      3'd4:    return (a < b) ? 16'd1 : 16'd0;
      default: return 16'd0;
    endcase
  endfunction

  // External ALU: result of the operands sampled LAT edges earlier.
  logic [15:0] alu_pipe [LAT];
  initial for (int i = 0; i < LAT; i++) alu_pipe[i] = '0;
  always @(posedge clock) begin
    alu_pipe[0] <= alu_f(alu_a, alu_b, alu_ctrl);
    for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_result = alu_pipe[LAT-1];
  assign alu_zero   = (alu_result == 16'd0);

  typedef struct packed {
    logic        ill;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  ctrl;
    logic [15:0] res;
    logic        tk;
  } exp_t;

  function automatic exp_t spec_model(input logic [3:0] op, input logic [2:0] fn,
                                      input logic [15:0] rs, input logic [15:0] rt,
                                      input logic [7:0] im);
    exp_t e;
    logic [15:0] simm;
    simm = {{8{im[7]}}, im};
    e = '0;
    e.a = rs;
    case (op)
      4'd0:             begin e.b = rt;   e.ctrl = fn;   e.ill = (fn > 3'd4); end
      4'd1, 4'd7, 4'd8: begin e.b = simm; e.ctrl = 3'd2; end
      4'd2:             begin e.b = simm; e.ctrl = 3'd0; end
      4'd3:             begin e.b = simm; e.ctrl = 3'd1; end
      4'd4:             begin e.b = simm; e.ctrl = 3'd4; end
      4'd5, 4'd6:       begin e.b = rt;   e.ctrl = 3'd3; end
      default:          e.ill = 1'b1;
    endcase
    e.res = alu_f(e.a, e.b, e.ctrl);
    e.tk  = (op == 4'd5) ? (e.res == 16'd0) : (op == 4'd6) ? (e.res != 16'd0) : 1'b0;
    if (e.ill) begin
      e.res = '0;
      e.tk  = 1'b0;
    end
    return e;
  endfunction

  // Transaction-level model: cycles remaining until the result is due,
  // whether a result is presented, and what the ALU was last given.
  int          mdl_wait  = 0;
  bit          mdl_valid = 1'b0;
  logic [15:0] mdl_a = '0, mdl_b = '0, mdl_res = '0;
  logic [2:0]  mdl_ctrl = '0;
  logic        mdl_tk = 1'b0, mdl_ill = 1'b0;
  exp_t        mdl_pend;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mdl_wait = 0; mdl_valid = 1'b0;
      mdl_a = '0; mdl_b = '0; mdl_ctrl = '0;
      mdl_res = '0; mdl_tk = 1'b0; mdl_ill = 1'b0;
    end else if (mdl_valid) begin
      if (out_ready) mdl_valid = 1'b0;
    end else if (mdl_wait > 0) begin
      mdl_wait--;
      if (mdl_wait == 0) begin
        mdl_valid = 1'b1;
        mdl_res   = mdl_pend.res;
        mdl_tk    = mdl_pend.tk;
        mdl_ill   = 1'b0;
      end
    end else if (in_valid) begin
      mdl_pend = spec_model(opcode, funct, rs_val, rt_val, imm);
      if (mdl_pend.ill) begin
        mdl_valid = 1'b1;
        mdl_ill   = 1'b1;
        mdl_res   = '0;
        mdl_tk    = 1'b0;
      end else begin
        mdl_a    = mdl_pend.a;
        mdl_b    = mdl_pend.b;
        mdl_ctrl = mdl_pend.ctrl;
        mdl_wait = LAT + 1;
      end
    end
  end

  always @(negedge clock) begin
    chk("cyc_in_ready",  32'(in_ready),  32'(mdl_wait == 0 && !mdl_valid));
    chk("cyc_out_valid", 32'(out_valid), 32'(mdl_valid));
    chk("cyc_alu_a",     32'(alu_a),     32'(mdl_a));
    chk("cyc_alu_b",     32'(alu_b),     32'(mdl_b));
    chk("cyc_alu_ctrl",  32'(alu_ctrl),  32'(mdl_ctrl));
    if (mdl_valid) begin
      chk("cyc_out_result",   32'(out_result),   32'(mdl_res));
      chk("cyc_branch_taken", 32'(branch_taken), 32'(mdl_tk));
      chk("cyc_illegal",      32'(illegal),      32'(mdl_ill));
    end
  end

  task automatic run_instr(input string nm, input logic [3:0] op, input logic [2:0] fn,
                           input logic [15:0] rs, input logic [15:0] rt, input logic [7:0] im,
                           input logic [15:0] x_b, input logic [2:0] x_ctrl,
                           input logic [15:0] x_res, input logic x_tk, input logic x_ill,
                           input int hold, input bit poke);
    int edges;
    @(posedge clock); #1;
    in_valid = 1'b1; opcode = op; funct = fn; rs_val = rs; rt_val = rt; imm = im;
    @(posedge clock); #1;
    in_valid = 1'b0;
    chk({nm, "_alu_b"},    32'(alu_b),    32'(x_b));
    chk({nm, "_alu_ctrl"}, 32'(alu_ctrl), 32'(x_ctrl));
    edges = 0;
    while (!out_valid && edges < 50) begin
      @(posedge clock); #1;
      edges++;
    end
    chk({nm, "_latency"},  32'(edges),        x_ill ? 32'd0 : 32'(LAT + 1));
    chk({nm, "_result"},   32'(out_result),   32'(x_res));
    chk({nm, "_taken"},    32'(branch_taken), 32'(x_tk));
    chk({nm, "_illegal"},  32'(illegal),      32'(x_ill));
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        in_valid = 1'b1; opcode = 4'd0; funct = 3'd2; rs_val = 16'hAAAA; rt_val = 16'h1111;
      end
      @(posedge clock); #1;
      chk({nm, "_hold_valid"},  32'(out_valid),  32'd1);
      chk({nm, "_hold_ready"},  32'(in_ready),   32'd0);
      chk({nm, "_hold_result"}, 32'(out_result), 32'(x_res));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk({nm, "_back_idle"}, 32'(in_ready),  32'd1);
    chk({nm, "_drop_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; funct = '0; rs_val = '0; rt_val = '0; imm = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_in_ready",  32'(in_ready),   32'd1);
    chk("rst_out_valid", 32'(out_valid),  32'd0);
    chk("rst_result",    32'(out_result), 32'd0);
    chk("rst_alu_a",     32'(alu_a),      32'd0);
    chk("rst_alu_ctrl",  32'(alu_ctrl),   32'd0);
    reset = 1'b0;

    //        name     op     fn     rs        rt        imm     x_b       ctrl  x_res     tk ill hold poke
    run_instr("add",   4'h0, 3'd2, 16'h0005, 16'h0003, 8'h00, 16'h0003, 3'd2, 16'h0008, 0, 0, 0, 0);
    run_instr("addi",  4'h1, 3'd0, 16'h0010, 16'h0000, 8'hFF, 16'hFFFF, 3'd2, 16'h000F, 0, 0, 0, 0);
    run_instr("slti",  4'h4, 3'd0, 16'h0001, 16'h0000, 8'h02, 16'h0002, 3'd4, 16'h0001, 0, 0, 0, 0);
    run_instr("beq_t", 4'h5, 3'd0, 16'h1234, 16'h1234, 8'h00, 16'h1234, 3'd3, 16'h0000, 1, 0, 0, 0);
    run_instr("bne_n", 4'h6, 3'd0, 16'h1234, 16'h1234, 8'h00, 16'h1234, 3'd3, 16'h0000, 0, 0, 0, 0);
    run_instr("ill_op",4'hF, 3'd0, 16'h7777, 16'h8888, 8'h11, 16'h1234, 3'd3, 16'h0000, 0, 1, 0, 0);
    run_instr("ill_fn",4'h0, 3'd6, 16'h7777, 16'h8888, 8'h11, 16'h1234, 3'd3, 16'h0000, 0, 1, 0, 0);
    run_instr("and",   4'h0, 3'd0, 16'hF0F0, 16'hFF00, 8'h00, 16'hFF00, 3'd0, 16'hF000, 0, 0, 0, 0);
    run_instr("or",    4'h0, 3'd1, 16'hF0F0, 16'hFF00, 8'h00, 16'hFF00, 3'd1, 16'hFFF0, 0, 0, 0, 0);
    run_instr("sub",   4'h0, 3'd3, 16'h0003, 16'h0005, 8'h00, 16'h0005, 3'd3, 16'hFFFE, 0, 0, 0, 0);
    run_instr("slt_n", 4'h0, 3'd4, 16'h0005, 16'h0003, 8'h00, 16'h0003, 3'd4, 16'h0000, 0, 0, 0, 0);
    run_instr("andi",  4'h2, 3'd0, 16'h1234, 16'h0000, 8'h0F, 16'h000F, 3'd0, 16'h0004, 0, 0, 0, 0);
    run_instr("ori",   4'h3, 3'd0, 16'h0100, 16'h0000, 8'h80, 16'hFF80, 3'd1, 16'hFF80, 0, 0, 0, 0);
    run_instr("lw",    4'h7, 3'd0, 16'h1000, 16'h0000, 8'h04, 16'h0004, 3'd2, 16'h1004, 0, 0, 0, 0);
    run_instr("bne_t", 4'h6, 3'd0, 16'h0001, 16'h0002, 8'h00, 16'h0002, 3'd3, 16'hFFFF, 1, 0, 0, 0);
    run_instr("beq_n", 4'h5, 3'd0, 16'h0001, 16'h0002, 8'h00, 16'h0002, 3'd3, 16'hFFFF, 0, 0, 0, 0);
    run_instr("stall", 4'h0, 3'd2, 16'h0100, 16'h0023, 8'h00, 16'h0023, 3'd2, 16'h0123, 0, 0, 5, 1);
    run_instr("sw",    4'h8, 3'd0, 16'h1000, 16'h0000, 8'hFC, 16'hFFFC, 3'd2, 16'h0FFC, 0, 0, 0, 0);

    // Reset pulsed while the instruction is in WAIT.
    @(posedge clock); #1;
    in_valid = 1'b1; opcode = 4'h0; funct = 3'd2; rs_val = 16'h0005; rt_val = 16'h0003;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    chk("mid_alu_a", 32'(alu_a), 32'h0005);
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid),    32'd0);
    chk("arst_in_ready",  32'(in_ready),     32'd1);
    chk("arst_alu_a",     32'(alu_a),        32'd0);
    chk("arst_alu_b",     32'(alu_b),        32'd0);
    chk("arst_alu_ctrl",  32'(alu_ctrl),     32'd0);
    chk("arst_result",    32'(out_result),   32'd0);
    chk("arst_taken",     32'(branch_taken), 32'd0);
    chk("arst_illegal",   32'(illegal),      32'd0);
    #2 reset = 1'b0;
    run_instr("post_rst", 4'h0, 3'd2, 16'h0100, 16'h0023, 8'h00, 16'h0023, 3'd2, 16'h0123, 0, 0, 0, 0);

    repeat (2) @(posedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
